// File: rtl/pcg_pkg.sv
// Shared types and constants for the PCG-XSH-RR 32->16 generator and its arbiter.
package pcg_pkg;

  typedef logic [31:0] pcg_state_t;
  typedef logic [15:0] pcg_out_t;

  typedef enum logic [1:0] {
    SEED_A = 2'd0,
    SEED_B = 2'd1,
    RUN    = 2'd2
  } fsm_t;

  localparam pcg_state_t PCG_MULT_DEF = 32'd747796405;
  localparam pcg_state_t PCG_INC_DEF  = 32'hAC564B05;

  // Left shift of (16-r)&15 is the same as a shift by -r modulo 16, so r=0 yields x.
  function automatic pcg_out_t rotr16(input pcg_out_t x, input logic [3:0] r);
    logic [3:0] w_l;
    w_l = 4'd0 - r;
    return (x >> r) | (x << w_l);
  endfunction

endpackage

// File: rtl/pcg_xsh_rr16.sv
// Combinational PCG-XSH-RR step: current state -> next LCG state and 16-bit output word.
module pcg_xsh_rr16
  import pcg_pkg::*;
#(
  parameter pcg_state_t MULT = PCG_MULT_DEF,
  parameter pcg_state_t INC  = PCG_INC_DEF
) (
  input  logic [31:0] i_state,
  output logic [31:0] o_next,
  output logic [15:0] o_rnd
);

  logic [15:0] w_xs;

  // Bits [27:12] of ((s>>10)^s): the shifted term contributes s[31:22] zero-extended.
  assign w_xs   = i_state[27:12] ^ {6'b000000, i_state[31:22]};
  assign o_next = i_state * MULT + INC;
  assign o_rnd  = rotr16(w_xs, i_state[31:28]);

endmodule

// File: rtl/pcg_rng_arbiter.sv
// Seeds one PCG-XSH-RR generator and shares its draws round-robin among N_REQ requesters.
// Build option: define PCG_FREE_RUN_EN to advance the generator every RUN cycle.
module pcg_rng_arbiter
  import pcg_pkg::*;
#(
  parameter int         N_REQ    = 3,
  parameter pcg_state_t MULT     = PCG_MULT_DEF,
  parameter pcg_state_t INC      = PCG_INC_DEF,
  parameter pcg_state_t SEED_DEF = 32'h0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_seed_load,
  input  logic [31:0]      i_seed_val,
  output logic             o_busy,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [N_REQ-1:0] o_rnd_vld,
  output logic [15:0]      o_rnd_data
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  fsm_t             r_fsm;
  pcg_state_t       r_seed;
  pcg_state_t       r_state;
  logic [PW-1:0]    r_ptr;
  logic [N_REQ-1:0] r_vld;
  pcg_out_t         r_data;

  pcg_state_t       w_next;
  pcg_out_t         w_rnd;
  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_found;
  logic             w_en;
  int               w_j;

  pcg_xsh_rr16 #(
    .MULT (MULT),
    .INC  (INC)
  ) u_step (
    .i_state (r_state),
    .o_next  (w_next),
    .o_rnd   (w_rnd)
  );

  // A seed request takes priority over any draw in the same cycle.
  assign w_en = (r_fsm == RUN) && !i_seed_load;

  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!w_found && i_req[w_j]) begin
        w_found = 1'b1;
        w_idx   = PW'(w_j);
      end
    end
    if (w_found && w_en) w_gnt[w_idx] = 1'b1;
  end

  assign w_ptr_nxt = (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + PW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm   <= SEED_A;
      r_seed  <= SEED_DEF;
      r_state <= '0;
      r_ptr   <= '0;
      r_vld   <= '0;
      r_data  <= '0;
    end else begin
      r_vld <= '0;
      if (i_seed_load) begin
        r_seed <= i_seed_val;
        r_fsm  <= SEED_A;
      end else begin
        case (r_fsm)
          SEED_A: begin
            r_state <= INC + r_seed;
            r_fsm   <= SEED_B;
          end
          SEED_B: begin
            r_state <= w_next;
            r_fsm   <= RUN;
          end
          RUN: begin
            if (|w_gnt) begin
              r_state <= w_next;
              r_data  <= w_rnd;
              r_vld   <= w_gnt;
              r_ptr   <= w_ptr_nxt;
            end
`ifdef PCG_FREE_RUN_EN
            else begin
              r_state <= w_next;
            end
`else
`endif
          end
          default: r_fsm <= SEED_A;
        endcase
      end
    end
  end

  assign o_busy     = (r_fsm != RUN);
  assign o_gnt      = w_gnt;
  assign o_rnd_vld  = r_vld;
  assign o_rnd_data = r_data;

endmodule
